// File: rtl/scandoubler_gen.sv
// 15 kHz to 31 kHz line doubler: two-bank line buffer, double-rate replay with
// optional scanline dimming on the second pass, regenerated VGA syncs, registered bypass.
module scandoubler_gen #(
  parameter int unsigned COLOR_BITS  = 3,
  parameter int unsigned LINE_BITS   = 10,
  parameter int unsigned MIN_LINE    = 128,
  parameter int unsigned HSYNC_COUNT = 41,
  parameter int unsigned VSYNC_COUNT = 1404
) (
  input  logic                  clkvga,
  input  logic                  reset,
  input  logic                  pix_ce,
  input  logic                  enable_scandoubling,
  input  logic [1:0]            scan_mode,
  input  logic [COLOR_BITS-1:0] ri,
  input  logic [COLOR_BITS-1:0] gi,
  input  logic [COLOR_BITS-1:0] bi,
  input  logic                  hsync_ext_n,
  input  logic                  vsync_ext_n,
  input  logic                  csync_ext_n,
  output logic [COLOR_BITS-1:0] ro,
  output logic [COLOR_BITS-1:0] go,
  output logic [COLOR_BITS-1:0] bo,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  lock
);

  localparam int unsigned PIX_W = 3 * COLOR_BITS;
  localparam int unsigned DEPTH = 1 << (LINE_BITS + 1);
  localparam logic [LINE_BITS-1:0] ADDR_MAX = '1;
  localparam logic [15:0] VS_LOAD = 16'(VSYNC_COUNT);

  logic [PIX_W-1:0]     r_mem [0:DEPTH-1];
  logic [PIX_W-1:0]     r_rdata;
  logic [LINE_BITS-1:0] r_waddr, r_raddr, r_totalhor;
  logic                 r_wbank, r_pass, r_ovf, r_lock;
  logic                 r_hs_prev, r_vsce_prev, r_vs_prev;
  logic [15:0]          r_vcnt;
  logic                 r_pass_d1, r_hs_d1, r_vs_d1, r_lock_d1;

  logic [PIX_W-1:0]      w_pix;
  logic                  w_sat, w_line_end, w_vs_rise, w_vs_fall, w_hs_int;
  logic [LINE_BITS-1:0]  w_waddr_inc;
  logic [COLOR_BITS-1:0] w_r, w_g, w_b;

  function automatic logic [COLOR_BITS-1:0] dim_chan(input logic [COLOR_BITS-1:0] x,
                                                     input logic p, input logic [1:0] m);
    if (!p) return x;
    case (m)
      2'b00:   return x;
      2'b01:   return x - (x >> 2);
      2'b10:   return x >> 1;
      default: return '0;
    endcase
  endfunction

  // The pixel that arrives with the accepted hsync edge closes the line, so it is counted in totalhor.
  assign w_pix       = {ri, gi, bi};
  assign w_sat       = (r_waddr == ADDR_MAX);
  assign w_waddr_inc = w_sat ? r_waddr : r_waddr + 1'b1;
  assign w_line_end  = pix_ce && r_hs_prev && !hsync_ext_n && (32'(w_waddr_inc) >= MIN_LINE);
  assign w_vs_rise   = pix_ce && !r_vsce_prev && vsync_ext_n;
  assign w_vs_fall   = r_vs_prev && !vsync_ext_n;
  assign w_hs_int    = !((32'(r_raddr) < HSYNC_COUNT) && (r_totalhor != '0));

  // Line buffer: write bank and read bank are always opposite.
  always_ff @(posedge clkvga) begin
    if (pix_ce) r_mem[{r_wbank, r_waddr}] <= w_pix;
    r_rdata <= r_mem[{~r_wbank, r_raddr}];
  end

  always_ff @(posedge clkvga) begin
    if (reset) begin
      r_waddr     <= '0;
      r_totalhor  <= '0;
      r_wbank     <= 1'b0;
      r_ovf       <= 1'b0;
      r_lock      <= 1'b0;
      r_hs_prev   <= 1'b1;
      r_vsce_prev <= 1'b1;
    end else if (pix_ce) begin
      r_hs_prev   <= hsync_ext_n;
      r_vsce_prev <= vsync_ext_n;
      if (w_line_end) begin
        r_totalhor <= w_waddr_inc;
        r_waddr    <= '0;
        r_ovf      <= 1'b0;
        r_lock     <= (w_waddr_inc == r_totalhor) && !(r_ovf || w_sat);
        r_wbank    <= w_vs_rise ? 1'b0 : ~r_wbank;
      end else begin
        r_waddr <= w_waddr_inc;
        if (w_sat) r_ovf <= 1'b1;
        if (w_vs_rise) r_wbank <= 1'b0;
      end
    end
  end

  // Replay each stored line twice per source line.
  always_ff @(posedge clkvga) begin
    if (reset) begin
      r_raddr <= '0;
      r_pass  <= 1'b0;
    end else if (w_line_end) begin
      r_raddr <= '0;
      r_pass  <= 1'b0;
    end else if (r_totalhor == '0) begin
      r_raddr <= '0;
    end else if (r_raddr == r_totalhor - 1'b1) begin
      r_raddr <= '0;
      r_pass  <= ~r_pass;
    end else begin
      r_raddr <= r_raddr + 1'b1;
    end
  end

  always_ff @(posedge clkvga) begin
    if (reset) begin
      r_vs_prev <= 1'b1;
      r_vcnt    <= '0;
    end else begin
      r_vs_prev <= vsync_ext_n;
      if (w_vs_fall)         r_vcnt <= VS_LOAD;
      else if (r_vcnt != '0) r_vcnt <= r_vcnt - 16'd1;
    end
  end

  // Control delayed one stage to sit alongside the RAM read data.
  always_ff @(posedge clkvga) begin
    if (reset) begin
      r_pass_d1 <= 1'b0;
      r_hs_d1   <= 1'b1;
      r_vs_d1   <= 1'b1;
      r_lock_d1 <= 1'b0;
    end else begin
      r_pass_d1 <= r_pass;
      r_hs_d1   <= w_hs_int;
      r_vs_d1   <= (r_vcnt == '0);
      r_lock_d1 <= r_lock;
    end
  end

  always_comb begin
    w_r = dim_chan(r_rdata[PIX_W-1 -: COLOR_BITS], r_pass_d1, scan_mode);
    w_g = dim_chan(r_rdata[2*COLOR_BITS-1 -: COLOR_BITS], r_pass_d1, scan_mode);
    w_b = dim_chan(r_rdata[COLOR_BITS-1:0], r_pass_d1, scan_mode);
  end

  always_ff @(posedge clkvga) begin
    if (reset) begin
      ro    <= '0;
      go    <= '0;
      bo    <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (!enable_scandoubling) begin
      ro    <= ri;
      go    <= gi;
      bo    <= bi;
      hsync <= csync_ext_n;
      vsync <= 1'b1;
    end else begin
      ro    <= r_lock_d1 ? w_r : '0;
      go    <= r_lock_d1 ? w_g : '0;
      bo    <= r_lock_d1 ? w_b : '0;
      hsync <= r_hs_d1;
      vsync <= r_vs_d1;
    end
  end

  assign lock = r_lock;

endmodule

// File: tb/tb_scandoubler_gen.sv
// Randomized bench for scandoubler_gen against a line-level reference model.
module tb_scandoubler_gen;

  localparam int VSC  = 1404;
  localparam int HSC  = 41;
  localparam int LMAX = 1023;

  logic       clkvga = 1'b0;
  logic       reset, pix_ce, enable_scandoubling;
  logic [1:0] scan_mode;
  logic [2:0] ri, gi, bi, ro, go, bo;
  logic       hsync_ext_n, vsync_ext_n, csync_ext_n;
  logic       hsync, vsync, lock;

  always #5 clkvga = ~clkvga;

  scandoubler_gen dut (
    .clkvga(clkvga), .reset(reset), .pix_ce(pix_ce),
    .enable_scandoubling(enable_scandoubling), .scan_mode(scan_mode),
    .ri(ri), .gi(gi), .bi(bi),
    .hsync_ext_n(hsync_ext_n), .vsync_ext_n(vsync_ext_n), .csync_ext_n(csync_ext_n),
    .ro(ro), .go(go), .bo(bo), .hsync(hsync), .vsync(vsync), .lock(lock)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: contents of each bank, last line length, lock, bank being written.
  logic [8:0] mbank [0:1][0:1023];
  logic [8:0] line_pix [0:1199];
  int m_L;
  bit m_lock;
  bit m_wbank;
  int vs_fall_cyc;
  int vs_low_cnt;

  task automatic tick();
    @(posedge clkvga);
    cyc++;
    @(negedge clkvga);
  endtask

  function automatic logic [2:0] dimc(input logic [2:0] x, input bit p, input logic [1:0] m);
    int v;
    v = int'(x);
    if (!p) return x;
    case (m)
      2'd0:    return x;
      2'd1:    return 3'(v - v / 4);
      2'd2:    return 3'(v / 2);
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic exp_vs();
    return !(cyc >= vs_fall_cyc + 2 && cyc <= vs_fall_cyc + VSC + 1);
  endfunction

  task automatic model_reset();
    m_L = 0;
    m_lock = 0;
    m_wbank = 0;
    vs_fall_cyc = -100000;
  endtask

  // Sends one source line of n pixels; checks the doubled output of the previous line meanwhile.
  task automatic send_line(input int n, input int glitch_at, input bit with_vs,
                           input bit rand_pix, input logic [8:0] fixed_pix);
    int p_L, bad_rgb, bad_hs, bad_vs, ra, L, idx;
    bit p_lock, p_rb, epass, ovf;
    logic [8:0] e_pix;
    logic [2:0] er, eg, eb;
    logic ehs, evs;
    p_L = m_L;
    p_lock = m_lock;
    p_rb = !m_wbank;
    bad_rgb = 0; bad_hs = 0; bad_vs = 0;
    for (int i = 0; i < n; i++) line_pix[i] = rand_pix ? 9'($urandom) : fixed_pix;
    for (int c = 0; c < 2 * n; c++) begin
      idx = c / 2 + 1;
      pix_ce = (c % 2 == 0);
      {ri, gi, bi} = line_pix[idx-1];
      hsync_ext_n = !(idx == n || idx <= 16 || idx == glitch_at);
      vsync_ext_n = !(with_vs && c >= 2 * n - 12 && c <= 2 * n - 3);
      if (with_vs && c == 2 * n - 12) vs_fall_cyc = cyc + 1;
      tick();
      ra = (p_L == 0) ? 0 : c % p_L;
      epass = (p_L == 0) ? 1'b0 : (((c / p_L) % 2) == 1);
      e_pix = mbank[p_rb][ra];
      er = p_lock ? dimc(e_pix[8:6], epass, scan_mode) : 3'd0;
      eg = p_lock ? dimc(e_pix[5:3], epass, scan_mode) : 3'd0;
      eb = p_lock ? dimc(e_pix[2:0], epass, scan_mode) : 3'd0;
      ehs = !(p_L != 0 && ra < HSC);
      evs = exp_vs();
      if ({ro, go, bo} !== {er, eg, eb}) bad_rgb++;
      if (hsync !== ehs) bad_hs++;
      if (vsync !== evs) bad_vs++;
      if (vsync === 1'b0) vs_low_cnt++;
      if (c == 2 * n - 2) begin
        L = (n > LMAX) ? LMAX : n;
        ovf = (n > LMAX);
        for (int i = 0; i < n; i++) mbank[m_wbank][(i > LMAX) ? LMAX : i] = line_pix[i];
        m_lock = (L == m_L) && !ovf;
        m_L = L;
        m_wbank = with_vs ? 1'b0 : !m_wbank;
      end
    end
    checks += 4;
    if (bad_rgb != 0) begin failures++; $display("FAIL line_rgb n=%0d: mismatching cycles %0d, required 0", n, bad_rgb); end
    if (bad_hs != 0)  begin failures++; $display("FAIL line_hsync n=%0d: mismatching cycles %0d, required 0", n, bad_hs); end
    if (bad_vs != 0)  begin failures++; $display("FAIL line_vsync n=%0d: mismatching cycles %0d, required 0", n, bad_vs); end
    if (lock !== m_lock) begin failures++; $display("FAIL line_lock n=%0d: got %b required %b", n, lock, m_lock); end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks += 4;
    if ({ro, go, bo} !== 9'd0) begin failures++; $display("FAIL %s_rgb: got %h required 000", tag, {ro, go, bo}); end
    if (hsync !== 1'b1) begin failures++; $display("FAIL %s_hsync: got %b required 1", tag, hsync); end
    if (vsync !== 1'b1) begin failures++; $display("FAIL %s_vsync: got %b required 1", tag, vsync); end
    if (lock !== 1'b0)  begin failures++; $display("FAIL %s_lock: got %b required 0", tag, lock); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pix_ce = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_lock();
    send_line(384, 0, 0, 1, 9'd0);
    send_line(384, 0, 0, 1, 9'd0);
    send_line(384, 0, 0, 1, 9'd0);
  endtask

  task automatic test_random_modes();
    for (int i = 0; i < 3; i++) begin
      scan_mode = 2'($urandom);
      send_line(384, 0, 0, 1, 9'd0);
    end
  endtask

  task automatic test_dim();
    send_line(384, 0, 0, 0, 9'h1FF);
    for (int m = 1; m <= 4; m++) begin
      scan_mode = 2'(m);
      send_line(384, 0, 0, 0, 9'h1FF);
    end
    scan_mode = 2'd2;
  endtask

  task automatic test_glitch();
    send_line(384, 50, 0, 1, 9'd0);
    send_line(384, 0, 0, 1, 9'd0);
  endtask

  task automatic test_vsync();
    if (m_wbank) send_line(384, 0, 0, 1, 9'd0);
    vs_low_cnt = 0;
    send_line(384, 0, 1, 1, 9'd0);
    send_line(384, 0, 0, 1, 9'd0);
    send_line(384, 0, 0, 1, 9'd0);
    checks++;
    if (vs_low_cnt != VSC) begin failures++; $display("FAIL vsync_width: got %0d cycles required %0d", vs_low_cnt, VSC); end
  endtask

  task automatic test_overflow();
    send_line(1100, 0, 0, 1, 9'd0);
    send_line(384, 0, 0, 1, 9'd0);
    send_line(384, 0, 0, 1, 9'd0);
    send_line(384, 0, 0, 1, 9'd0);
  endtask

  task automatic test_bypass();
    int bad;
    logic [8:0] drv;
    logic cs;
    bad = 0;
    enable_scandoubling = 1'b0;
    hsync_ext_n = 1'b1;
    vsync_ext_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      pix_ce = (c % 2 == 0);
      drv = (c < 4) ? {3'd5, 3'd5, 3'd5} : 9'($urandom);
      cs = (c % 3 == 0);
      {ri, gi, bi} = drv;
      csync_ext_n = cs;
      tick();
      if ({ro, go, bo} !== drv || hsync !== cs || vsync !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bypass: mismatching cycles %0d, required 0", bad); end
    csync_ext_n = 1'b1;
  endtask

  task automatic test_reset_midline();
    hsync_ext_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      pix_ce = (c % 2 == 0);
      {ri, gi, bi} = 9'($urandom);
      tick();
    end
    reset = 1'b1;
    pix_ce = 1'b0;
    repeat (2) tick();
    check_reset_outputs("midreset");
    reset = 1'b0;
    enable_scandoubling = 1'b1;
    model_reset();
    send_line(384, 0, 0, 1, 9'd0);
    send_line(384, 0, 0, 1, 9'd0);
    send_line(384, 0, 0, 1, 9'd0);
  endtask

  initial begin
    reset = 1'b1;
    pix_ce = 1'b0;
    enable_scandoubling = 1'b1;
    scan_mode = 2'd0;
    {ri, gi, bi} = 9'd0;
    hsync_ext_n = 1'b1;
    vsync_ext_n = 1'b1;
    csync_ext_n = 1'b1;
    vs_low_cnt = 0;
    model_reset();
    test_reset();
    test_lock();
    test_random_modes();
    test_dim();
    test_glitch();
    test_vsync();
    test_overflow();
    test_bypass();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scandoubler_gen.md
# scandoubler_gen

Parametrised single-clock line doubler that converts 15 kHz RGB video (source pixels qualified by a clock enable) into 31 kHz VGA timing. It stores each incoming line in a two-bank line buffer, measures its length, replays it twice per source line with selectable scanline dimming on the second pass, and regenerates VGA hsync/vsync. It sits between the video generator and the VGA pins, with a registered 15 kHz bypass mode.

## Interface
- COLOR_BITS, 3, bits per colour channel
- LINE_BITS, 10, line-buffer address width per bank (max 2^LINE_BITS source pixels per line)
- MIN_LINE, 128, minimum write count for a source hsync to be accepted as end of line
- HSYNC_COUNT, 41, VGA hsync low width in clkvga cycles
- VSYNC_COUNT, 1404, VGA vsync low width in clkvga cycles (16-bit counter)

- clkvga  in  1  system/VGA pixel clock
- reset  in  1  synchronous, active-high
- pix_ce  in  1  source pixel strobe; exactly every second clkvga cycle
- enable_scandoubling  in  1  1 = VGA output, 0 = 15 kHz bypass
- scan_mode  in  2  00 none, 01 75%, 10 50%, 11 black scanlines
- ri, gi, bi  in  COLOR_BITS each  source colour
- hsync_ext_n, vsync_ext_n, csync_ext_n  in  1  source syncs, active low
- ro, go, bo  out  COLOR_BITS each  output colour, registered
- hsync, vsync  out  1  output syncs, registered, active low
- lock  out  1  line length stable over two consecutive lines

## Operation
- Write side, on pix_ce only: buffer[wbank][waddr] <= {ri,gi,bi}; waddr increments and saturates at 2^LINE_BITS-1 (no wrap; sets ovf).
- Line end: hsync_ext_n falling edge (sampled on pix_ce) with waddr >= MIN_LINE: totalhor <= waddr, waddr <= 0, wbank toggles, ovf cleared, line_start pulse. Falling edges with waddr < MIN_LINE are ignored.
- vsync_ext_n rising edge (pix_ce): wbank <= 0. If coincident with a line end, line end takes effect first and then wbank is forced to 0.
- lock: set when the new totalhor equals the previous one and ovf was 0; cleared otherwise.
- Read side, every clkvga: reads bank ~wbank at raddr. On line_start: raddr <= 0, pass <= 0. Otherwise, when raddr == totalhor-1: raddr <= 0, pass toggles. Otherwise raddr increments. While totalhor == 0, raddr is held at 0.
- Dimming, applied when pass == 1 (per channel x): 00 x; 01 x - (x>>2); 10 x>>1; 11 0. pass == 0 is always full brightness.
- VGA hsync low while raddr < HSYNC_COUNT and totalhor != 0.
- VGA vsync: a vsync_ext_n falling edge (clkvga-sampled) loads the counter and drives vsync low for exactly VSYNC_COUNT cycles, then high. An early rise of vsync_ext_n does not shorten the pulse. A new falling edge during the pulse restarts it.
- Doubling mode with lock == 0: ro/go/bo forced to 0; syncs still generated.
- Bypass: ro/go/bo <= ri/gi/bi, hsync <= csync_ext_n, vsync <= 1, each registered one cycle. Write/read logic keeps running.

## Timing
- Reset: waddr, raddr, wbank, pass, totalhor, ovf, lock, vsync counter = 0. Outputs: rgb 0, hsync 1, vsync 1. RAM contents undefined.
- Doubling-mode latency: 2 clkvga from raddr to pins (RAM read + output register). Internal hsync/vsync are delayed 2 stages to stay aligned with pixels.
- Bypass latency: 1 clkvga.
- Write-to-read hazard is impossible: the read bank is always the bank not being written.
- Mode switch takes effect on the next clock. Reset mid-line discards the partial line; lock returns after two valid lines.
- Buffer: 2 x 2^LINE_BITS x 3*COLOR_BITS, inferred dual-port block RAM.

## Test plan
- Steady lines of 384 source pixels (768 clkvga), HSYNC_COUNT 41 -> lock high after 2nd line end; each source line gives 2 VGA lines of 384 clkvga; hsync low exactly 41 cycles at each start.
- Pixel value 7 on all channels, scan_mode 01/10/11 -> pass 0 outputs 7; pass 1 outputs 6/3/0; scan_mode 00 outputs 7 on both passes.
- Glitch hsync falling at waddr 50 -> ignored; totalhor unchanged; lock stays high.
- Line of 1100 pixels with LINE_BITS 10 -> waddr saturates at 1023, lock clears, rgb 0, hsync continues.
- vsync_ext_n low for 10 cycles -> vsync low for exactly 1404 cycles. Coincident vsync rise and line end -> wbank 0.
- Bypass: ri=5, csync_ext_n toggling -> ro=5 and hsync=csync one cycle later, vsync 1. Reset -> hsync=vsync=1, rgb=0, lock=0.
